// File: rtl/regfile_sb_if.sv
// Register-file port bundle: read ports, write-back, issue tracking and status.
// Driver (core side) uses master; regfile_sb uses slave.
interface regfile_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  localparam int NREG = 2 ** ADDR_W;

  logic [ADDR_W-1:0] Rs;
  logic [ADDR_W-1:0] Rt;
  logic              RegWre;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              IssueValid;
  logic [ADDR_W-1:0] IssueReg;
  logic [DATA_W-1:0] PcAddr0;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              Stall;
  logic [NREG-1:0]   BusyVec;
  logic [DATA_W-1:0] RegPeek1;

  modport master (
    output Rs, Rt, RegWre, WriteReg, WriteData, IssueValid, IssueReg, PcAddr0,
    input  ReadData1, ReadData2, Stall, BusyVec, RegPeek1
  );

  modport slave (
    input  Rs, Rt, RegWre, WriteReg, WriteData, IssueValid, IssueReg, PcAddr0,
    output ReadData1, ReadData2, Stall, BusyVec, RegPeek1
  );
endinterface

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write-back bypass and a busy-bit scoreboard.
// Reads are combinational; state updates on the falling edge of Clk.
module regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_IDX = 0,
  parameter int PC_IDX   = 15,
  parameter int T_IDX    = 14,
  parameter int T_MODE   = 0,
  parameter int PEEK_IDX = 7
) (
  input  logic         Clk,
  input  logic         Rst,
  regfile_sb_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] L_ZERO = ADDR_W'(ZERO_IDX);
  localparam logic [ADDR_W-1:0] L_PC   = ADDR_W'(PC_IDX);
  localparam logic [ADDR_W-1:0] L_T    = ADDR_W'(T_IDX);
  localparam logic [ADDR_W-1:0] L_PEEK = ADDR_W'(PEEK_IDX);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_busy;

  logic              w_wr_ok;
  logic              w_iss_ok;
  logic              w_t_bit;
  logic [DATA_W-1:0] w_wr_val;
  logic              w_byp1;
  logic              w_byp2;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic [NREG-1:0]   w_busy_nxt;

  assign w_wr_ok  = bus.RegWre && (bus.WriteReg != L_ZERO) && (bus.WriteReg != L_PC);
  assign w_iss_ok = bus.IssueValid && (bus.IssueReg != L_ZERO) && (bus.IssueReg != L_PC);

  assign w_t_bit  = (T_MODE == 0) ? (bus.WriteData == '0) : bus.WriteData[0];
  assign w_wr_val = (bus.WriteReg == L_T) ? {{(DATA_W-1){1'b0}}, w_t_bit} : bus.WriteData;

  assign w_byp1 = w_wr_ok && (bus.WriteReg == bus.Rs);
  assign w_byp2 = w_wr_ok && (bus.WriteReg == bus.Rt);

  always_comb begin
    w_rd1 = r_regs[bus.Rs];
    if (bus.Rs == L_ZERO)    w_rd1 = '0;
    else if (bus.Rs == L_PC) w_rd1 = bus.PcAddr0;
    else if (w_byp1)         w_rd1 = w_wr_val;
  end

  always_comb begin
    w_rd2 = r_regs[bus.Rt];
    if (bus.Rt == L_ZERO)    w_rd2 = '0;
    else if (bus.Rt == L_PC) w_rd2 = bus.PcAddr0;
    else if (w_byp2)         w_rd2 = w_wr_val;
  end

  // Issue is applied after the clear so a same-index new producer keeps the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok)  w_busy_nxt[bus.WriteReg] = 1'b0;
    if (w_iss_ok) w_busy_nxt[bus.IssueReg] = 1'b1;
  end

  always_ff @(negedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr_ok) r_regs[bus.WriteReg] <= w_wr_val;
      r_busy <= w_busy_nxt;
    end
  end

  assign bus.ReadData1 = w_rd1;
  assign bus.ReadData2 = w_rd2;
  assign bus.Stall     = (r_busy[bus.Rs] & ~w_byp1) | (r_busy[bus.Rt] & ~w_byp2);
  assign bus.BusyVec   = r_busy;
  assign bus.RegPeek1  = r_regs[L_PEEK];
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 16, register and data width in bits.
REQ-002 Parameter ADDR_W, default 4, register index width; register count NREG = 2^ADDR_W.
REQ-003 Parameter ZERO_IDX, default 0, hard-wired zero register index.
REQ-004 Parameter PC_IDX, default 15, index that reads PcAddr0.
REQ-005 Parameter T_IDX, default 14, index of the condition (T) register.
REQ-006 Parameter T_MODE, default 0, T write rule: 0 = store (WriteData==0), 1 = store WriteData[0]; stored value is zero-extended to DATA_W.
REQ-007 Parameter PEEK_IDX, default 7, register index driven on RegPeek1.
REQ-008 Clk  input  1  clock; all state updates on the falling edge.
REQ-009 Rst  input  1  asynchronous, active-low reset.
REQ-010 Rs  input  ADDR_W  read port 1 index.
REQ-011 Rt  input  ADDR_W  read port 2 index.
REQ-012 RegWre  input  1  write-back enable.
REQ-013 WriteReg  input  ADDR_W  write-back index.
REQ-014 WriteData  input  DATA_W  write-back data.
REQ-015 IssueValid  input  1  an instruction with a register destination is issued this cycle.
REQ-016 IssueReg  input  ADDR_W  destination index of the issued instruction.
REQ-017 PcAddr0  input  DATA_W  value returned for reads of PC_IDX.
REQ-018 ReadData1  output  DATA_W  read port 1 data.
REQ-019 ReadData2  output  DATA_W  read port 2 data.
REQ-020 Stall  output  1  Rs or Rt has an outstanding producer.
REQ-021 BusyVec  output  NREG  per-register pending-write bits.
REQ-022 RegPeek1  output  DATA_W  current contents of register PEEK_IDX, unbypassed.

Function
REQ-023 Reads SHALL be combinational: index ZERO_IDX -> 0; PC_IDX -> PcAddr0; otherwise stored value, or the bypass value per REQ-024.
REQ-024 When RegWre=1, WriteReg equals the read index, and the index is neither ZERO_IDX nor PC_IDX, the port SHALL return the value that will be written at the next falling edge (T-transformed if T_IDX).
REQ-025 On a falling edge with RegWre=1: WriteReg=ZERO_IDX or PC_IDX -> no storage change; WriteReg=T_IDX -> store per T_MODE; otherwise store WriteData.
REQ-026 On a falling edge with IssueValid=1 and IssueReg not ZERO_IDX or PC_IDX, BusyVec[IssueReg] SHALL be set.
REQ-027 On a falling edge with RegWre=1, BusyVec[WriteReg] SHALL be cleared unless REQ-028 applies.
REQ-028 Issue and write-back to the same index in the same edge: bit SHALL remain set, because the new producer wins.
REQ-029 Issue and write-back to different indices in the same edge: both updates SHALL take effect.
REQ-030 BusyVec[ZERO_IDX] and BusyVec[PC_IDX] SHALL always be 0.
REQ-031 Stall = (BusyVec[Rs] & ~byp1) | (BusyVec[Rt] & ~byp2), combinational, where bypN is the REQ-024 bypass condition for that port.
REQ-032 Re-issue to an already-busy index SHALL leave its bit set, with no counting; one write-back clears it.
REQ-033 Write-back to a non-busy index SHALL write data normally; BusyVec is unchanged.
REQ-034 RegWre=0 and IssueValid=0 SHALL leave all state unchanged.

Reset
REQ-035 Rst=0 SHALL immediately clear all NREG registers and all BusyVec bits, independent of Clk.
REQ-036 During reset, outputs SHALL be: ReadData1/2 = 0, except PcAddr0 when reading PC_IDX or the bypass value when REQ-024 applies; RegPeek1 = 0; Stall = 0; BusyVec = 0.
REQ-037 A write or issue coincident with reset assertion SHALL be discarded; reset release mid-operation SHALL resume from the all-zero state at the next falling edge.
REQ-038 No initial-block state is required; reset alone defines contents.

Verification
REQ-039 Reset, then write 0x1234 to r3, read Rs=3 -> 0x1234; Rs=0 -> 0x0000; Rs=15 with PcAddr0=0x00A0 -> 0x00A0.
REQ-040 With T_MODE=0: write 0 to T_IDX -> 0x0001; write 0x0005 -> 0x0000. With T_MODE=1: write 0x0005 -> 0x0001.
REQ-041 Issue r5, set Rs=5 -> Stall=1, BusyVec[5]=1; next cycle RegWre=1, WriteReg=5, WriteData=0xBEEF -> Stall=0, ReadData1=0xBEEF before the edge; after the edge BusyVec[5]=0.
REQ-042 Issue r6 and write-back r6 in the same edge -> BusyVec[6]=1 after the edge, r6 holds the written data.
REQ-043 Issue to ZERO_IDX or PC_IDX, and write 0xFFFF to r0 -> BusyVec=0, r0 reads 0.
REQ-044 Fill r7=0x00FF, issue r2, assert Rst low between edges -> RegPeek1=0, BusyVec=0, Stall=0 immediately.
